// File: rtl/udp_mux_pkg.sv
// Shared types and constants for the UDP stream multiplexer.
package udp_mux_pkg;
  typedef enum logic [1:0] {T_IDLE, T_HDR, T_BODY} tx_state_t;
  typedef enum logic [1:0] {R_HDR, R_BODY, R_DROP} rx_state_t;

  localparam int UDPMUX_ID_BYTES = 1;
  localparam int DROP_CNT_W      = 16;
endpackage

// File: rtl/udp_stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   last_grant,
  output logic [ID_W-1:0]   grant,
  output logic              valid
);
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    return ID_W'((int'(base) + off) % NUM_CH);
  endfunction

  // Walk from the farthest candidate inwards so the nearest requester is written last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (req[rr_idx(last_grant, i)]) begin
        grant = rr_idx(last_grant, i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/udp_stream_mux.sv
// N-channel packet mux onto one UDP byte stream with a channel-ID prefix byte,
// and the matching RX demux. Optional drop counter: UDPMUX_DROP_CNT_EN.
module udp_stream_mux
  import udp_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  UDP_Connected,
  input  logic [8*NUM_CH-1:0]   Ch_TxData,
  input  logic [NUM_CH-1:0]     Ch_TxValid,
  input  logic [NUM_CH-1:0]     Ch_TxLast,
  output logic [NUM_CH-1:0]     Ch_TxReady,
  output logic [7:0]            UDP_TxData,
  output logic                  UDP_TxValid,
  output logic                  UDP_TxLast,
  input  logic                  UDP_TxReady,
  input  logic [7:0]            UDP_RxData,
  input  logic                  UDP_RxValid,
  input  logic                  UDP_RxLast,
  output logic                  UDP_RxReady,
  output logic [7:0]            Ch_RxData,
  output logic                  Ch_RxLast,
  output logic [NUM_CH-1:0]     Ch_RxValid,
  input  logic [NUM_CH-1:0]     Ch_RxReady
`ifdef UDPMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] Drop_Count
`endif
);
  localparam int HDR_W = 8 * UDPMUX_ID_BYTES;

  // ---------------- TX ----------------
  tx_state_t                tx_state;
  logic [ID_W-1:0]          tx_grant, last_grant, arb_grant;
  logic                     arb_valid, tx_body_xfer;
  logic [NUM_CH-1:0][7:0]   tx_bytes;

  assign tx_bytes = Ch_TxData;

  rr_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_arb (
    .req        (Ch_TxValid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign tx_body_xfer = (tx_state == T_BODY) && Ch_TxValid[tx_grant] && UDP_TxReady;

  // Connection state gates only new grants; an in-flight packet always completes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tx_state   <= T_IDLE;
      tx_grant   <= '0;
      last_grant <= ID_W'(NUM_CH - 1);
    end else begin
      case (tx_state)
        T_IDLE: if (UDP_Connected && arb_valid) begin
          tx_grant   <= arb_grant;
          last_grant <= arb_grant;
          tx_state   <= T_HDR;
        end
        T_HDR:  if (UDP_TxReady) tx_state <= T_BODY;
        T_BODY: if (tx_body_xfer && Ch_TxLast[tx_grant]) tx_state <= T_IDLE;
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  always_comb begin
    UDP_TxData  = '0;
    UDP_TxValid = 1'b0;
    UDP_TxLast  = 1'b0;
    Ch_TxReady  = '0;
    case (tx_state)
      T_HDR: begin
        UDP_TxData  = HDR_W'(tx_grant);
        UDP_TxValid = 1'b1;
      end
      T_BODY: begin
        UDP_TxData           = tx_bytes[tx_grant];
        UDP_TxValid          = Ch_TxValid[tx_grant];
        UDP_TxLast           = Ch_TxLast[tx_grant];
        Ch_TxReady[tx_grant] = UDP_TxReady;
      end
      default: ;
    endcase
  end

  // ---------------- RX ----------------
  rx_state_t       rx_state;
  logic [ID_W-1:0] rx_id;
  logic            hdr_xfer, id_ok, drop_evt;

  assign hdr_xfer = (rx_state == R_HDR) && UDP_RxValid;
  assign id_ok    = int'(UDP_RxData) < NUM_CH;
  assign drop_evt = hdr_xfer && (UDP_RxLast || !id_ok);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_state <= R_HDR;
      rx_id    <= '0;
    end else begin
      case (rx_state)
        R_HDR: if (hdr_xfer) begin
          rx_id <= UDP_RxData[ID_W-1:0];
          if (!UDP_RxLast) rx_state <= id_ok ? R_BODY : R_DROP;
        end
        R_BODY: if (UDP_RxValid && Ch_RxReady[rx_id] && UDP_RxLast) rx_state <= R_HDR;
        R_DROP: if (UDP_RxValid && UDP_RxLast) rx_state <= R_HDR;
        default: rx_state <= R_HDR;
      endcase
    end
  end

  always_comb begin
    Ch_RxData   = UDP_RxData;
    Ch_RxLast   = 1'b0;
    Ch_RxValid  = '0;
    UDP_RxReady = 1'b1;
    if (rx_state == R_BODY) begin
      Ch_RxLast         = UDP_RxLast;
      Ch_RxValid[rx_id] = UDP_RxValid;
      UDP_RxReady       = Ch_RxReady[rx_id];
    end
  end

`ifdef UDPMUX_DROP_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                           Drop_Count <= '0;
    else if (drop_evt && Drop_Count != '1) Drop_Count <= Drop_Count + 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop_evt;
`endif
endmodule

// File: doc/udp_stream_mux.md
# udp_stream_mux

Parametrised N-channel stream multiplexer placed between user logic and the single UDP basic-server byte stream of the FC1001 MII core. The TX path round-robins whole packets from NUM_CH channel streams onto one UDP stream, prefixing each with a channel-ID byte. The RX path strips that byte and routes the packet body to the addressed channel. Packets with an invalid ID are discarded.

## Interface
- NUM_CH, 4: channel count, 2..16.
- ID_W, $clog2(NUM_CH): width of grant/ID registers. The ID byte on the wire is always 8 bits, zero-extended.
- Clk  in  1  system clock (100 MHz); all logic is single-clock.
- Reset  in  1  asynchronous, active-high reset.
- UDP_Connected  in  1  core reports client connected; new TX packets are granted only while high.
- Ch_TxData  in  8*NUM_CH  per-channel TX byte; channel k occupies bits [8k+7:8k].
- Ch_TxValid / Ch_TxLast  in  NUM_CH  per-channel valid / end-of-packet.
- Ch_TxReady  out  NUM_CH  per-channel ready.
- UDP_TxData  out  8; UDP_TxValid, UDP_TxLast  out  1; UDP_TxReady  in  1. These form the stream to the core.
- UDP_RxData  in  8; UDP_RxValid, UDP_RxLast  in  1; UDP_RxReady  out  1. These form the stream from the core.
- Ch_RxData  out  8  RX byte shared by all channels.
- Ch_RxLast  out  1  RX end-of-packet, shared.
- Ch_RxValid  out  NUM_CH  one-hot valid to the addressed channel.
- Ch_RxReady  in  NUM_CH  per-channel ready.
- Drop_Count  out  16  dropped RX packet count. Present only with UDPMUX_DROP_CNT_EN.

## Operation
- A transfer occurs on any stream when valid and ready are both high at a rising Clk.
- TX FSM has three states: T_IDLE, T_HDR, T_BODY.
  - T_IDLE: all TX outputs are 0. If UDP_Connected is high and any Ch_TxValid is high, grant the first requesting channel searching from (last_grant+1) mod NUM_CH upward, register it, and go to T_HDR.
  - T_HDR: UDP_TxData = grant ID, UDP_TxValid = 1, UDP_TxLast = 0, Ch_TxReady = 0. On UDP_TxReady, go to T_BODY.
  - T_BODY: combinational pass-through of the granted channel's data, valid and last. Ch_TxReady[grant] = UDP_TxReady; all other channels' ready = 0. When a transfer with Ch_TxLast occurs, go to T_IDLE.
- RX FSM has three states: R_HDR, R_BODY, R_DROP.
  - R_HDR: UDP_RxReady = 1 and Ch_RxValid = 0. On transfer, latch the ID.
    - If UDP_RxLast is set (header-only packet), the packet is dropped and the FSM stays in R_HDR.
    - Else if ID < NUM_CH, go to R_BODY.
    - Else the packet is dropped and the FSM goes to R_DROP.
  - R_BODY: Ch_RxData = UDP_RxData, Ch_RxLast = UDP_RxLast, Ch_RxValid[id] = UDP_RxValid, UDP_RxReady = Ch_RxReady[id]. A transfer with last returns the FSM to R_HDR.
  - R_DROP: UDP_RxReady = 1; consume bytes until a transfer with last, then go to R_HDR.
- TX and RX run fully independently.
- Boundary conditions:
  - UDP_Connected falling during T_HDR or T_BODY does not abort; the packet completes.
  - A channel deasserting valid mid-packet only stalls the stream; the grant is held.
  - If only one channel requests, it is re-granted back-to-back.
  - last_grant resets to NUM_CH-1, so channel 0 wins first.
  - Reset mid-packet returns both FSMs to T_IDLE / R_HDR. The partial packet is not completed; the core is reset with the same signal.

## Timing
- Reset values: all Ch_TxReady, Ch_RxValid, UDP_TxValid, UDP_TxLast and UDP_TxData are 0. UDP_RxReady = 1 (R_HDR). Drop_Count = 0.
- TX latency: request at cycle 0 gives the header valid at cycle 1 and the first body byte offered at cycle 2, provided UDP_TxReady stays high.
- TX overhead per packet is 2 cycles (arbitration + header). Body throughput is 1 byte/cycle.
- RX has zero added latency in R_BODY (combinational path). The header byte costs 1 cycle.
- Registered state: FSM states, grant, last_grant, RX ID, Drop_Count. Data paths are combinational muxes.

## Configuration
- UDPMUX_DROP_CNT_EN defined: Drop_Count port exists.
  - Increments by 1, saturating at 16'hFFFF, at the header transfer of every dropped packet (invalid ID or header-only).
- Undefined: port and counter are absent; drop behaviour is otherwise identical.

## Structure
- Package udp_mux_pkg holds:
  - TX state enum (T_IDLE/T_HDR/T_BODY) and RX state enum (R_HDR/R_BODY/R_DROP).
  - UDPMUX_ID_BYTES = 1.
  - Drop counter width constant = 16.
- Sub-module rr_arbiter (NUM_CH requests, last_grant in, grant/valid out, combinational).

## Test plan
- Reset, then NUM_CH=4, ch2 sends bytes 0xA1,0xA2(last) with ready high -> UDP stream is 0x02,0xA1,0xA2 with last on 0xA2, first valid on cycle 1.
- Ch0..3 all request continuously -> grants in order 0,1,2,3,0, with each packet prefixed by its ID and never interleaved.
- RX 0x01,0x55,0x66(last) -> Ch_RxValid = 4'b0010 for 0x55,0x66, Ch_RxLast with 0x66, no valid on other channels.
- RX 0x07,0x11,0x22(last) with NUM_CH=4 -> no Ch_RxValid; with macro defined, Drop_Count = 1. Header-only 0x00(last) -> Drop_Count = 2.
- Random backpressure on UDP_TxReady and Ch_RxReady (50%) with 1000 random packets -> scoreboards match byte-exact with no loss or duplication.
- Reset asserted mid-T_BODY and mid-R_BODY -> next cycle outputs at their reset values; a fresh packet afterwards passes correctly.
